// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result/handshake bundle for alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ALU_control_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;
  logic             busy_o;
  logic             done_o;
  modport master (
    output start_i, src1_i, src2_i, ALU_control_i,
    input  result_o, result_hi_o, zero_o, cout_o, overflow_o, busy_o, done_o
  );
  modport slave (
    input  start_i, src1_i, src2_i, ALU_control_i,
    output result_o, result_hi_o, zero_o, cout_o, overflow_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with single-cycle logic/arith ops and iterative unsigned MUL/DIV
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk_i,
  input logic       rst_i,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  state_t           r_state, w_state_n;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [WIDTH-1:0] r_res, r_res_hi;
  logic             r_zero, r_cout, r_ovf;
  logic             w_acc, w_iter, w_sub, w_sovf, w_cout, w_ovf, w_ge, w_last;
  logic [WIDTH-1:0] w_a, w_b, w_bb, w_res, w_diff, w_hi_n, w_lo_n;
  logic [WIDTH:0]   w_sum, w_mac, w_sh;
  logic [3:0]       w_op;

  assign w_a    = bus.src1_i;
  assign w_b    = bus.src2_i;
  assign w_op   = bus.ALU_control_i;
  assign w_acc  = bus.start_i && r_state != RUN;
  assign w_iter = w_op == OP_MULU || w_op == OP_DIVU;
  assign w_last = r_cnt == CNT_W'(1);

  // SUB and SLT share the A + ~B + 1 adder path
  always_comb begin
    w_sub  = w_op == OP_SUB || w_op == OP_SLT;
    w_bb   = w_sub ? ~w_b : w_b;
    w_sum  = {1'b0, w_a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_sub};
    w_sovf = (w_a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    w_res  = w_op == OP_AND ? (w_a & w_b) :
             w_op == OP_OR  ? (w_a | w_b) :
             (w_op == OP_ADD || w_op == OP_SUB) ? w_sum[WIDTH-1:0] :
             w_op == OP_SLT ? {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_sovf} :
             w_op == OP_NOR ? ~(w_a | w_b) : '0;
    w_cout = (w_op == OP_ADD || w_op == OP_SUB) && w_sum[WIDTH];
    w_ovf  = (w_op == OP_ADD || w_sub) && w_sovf;
  end

  // One step of shift-add multiply or restoring divide over {r_hi, r_lo}
  always_comb begin
    w_mac  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    w_ge   = w_sh >= {1'b0, r_b};
    w_diff = w_sh[WIDTH-1:0] - r_b;
    w_hi_n = r_op == OP_MULU ? w_mac[WIDTH:1] : (w_ge ? w_diff : w_sh[WIDTH-1:0]);
    w_lo_n = r_op == OP_MULU ? {w_mac[0], r_lo[WIDTH-1:1]} : {r_lo[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_state_n = r_state == RUN ? (w_last ? DONE : RUN) :
                w_acc ? (w_iter ? RUN : DONE) : IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_acc) begin
      r_op  <= w_op;
      r_cnt <= w_iter ? CNT_W'(WIDTH) : '0;
      r_hi  <= '0;
      r_lo  <= w_a;
      r_b   <= w_b;
      if (!w_iter) begin
        r_res    <= w_res;
        r_res_hi <= '0;
        r_zero   <= w_res == '0;
        r_cout   <= w_cout;
        r_ovf    <= w_ovf;
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      if (w_last) begin
        r_res    <= w_lo_n;
        r_res_hi <= w_hi_n;
        r_zero   <= w_lo_n == '0;
        r_cout   <= 1'b0;
        r_ovf    <= r_op == OP_DIVU && r_b == '0;
      end
    end
  end

  assign bus.result_o    = r_res;
  assign bus.result_hi_o = r_res_hi;
  assign bus.zero_o      = r_zero;
  assign bus.cout_o      = r_cout;
  assign bus.overflow_o  = r_ovf;
  assign bus.busy_o      = r_state == RUN;
  assign bus.done_o      = r_state == DONE;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the lab combinational ALU, for the pipelined/multi-cycle CPU datapath.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) return a registered result one cycle after acceptance.
- Iterative ops (unsigned MUL, unsigned DIV) run a shift-add / restoring-divide engine over WIDTH cycles.
- A start/busy/done handshake lets the controller stall until the result is ready.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  request; accepted when start_i=1 and busy_o=0
src1_i  input  WIDTH  operand A (dividend for DIV)
src2_i  input  WIDTH  operand B (divisor for DIV)
ALU_control_i  input  4  operation select, sampled at acceptance
result_o  output  WIDTH  result / product low half / quotient
result_hi_o  output  WIDTH  product high half / remainder; 0 for single-cycle ops
zero_o  output  1  result_o == 0
cout_o  output  1  carry out (ADD/SUB only, else 0)
overflow_o  output  1  signed overflow (ADD/SUB/SLT), divide-by-zero (DIV), else 0
busy_o  output  1  iterative op in progress
done_o  output  1  one-cycle pulse: outputs valid and updated

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: all outputs 0.
  - Internal state: FSM to IDLE, counter 0, operands cleared.
  - Mid-operation reset aborts the op; no done_o pulse follows.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, uses the overflow-corrected sign), 1100 NOR: single-cycle.
  - 1000 MULU, 1001 DIVU: iterative.
  - Any other code: result 0, zero_o=1, flags 0, single-cycle done.
- Operands and opcode are latched at acceptance; input changes afterwards have no effect.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start_i=1, single-cycle op: at edge k, result and flags registered, FSM to DONE. done_o=1 for the cycle after edge k. busy_o stays 0.
  - IDLE, start_i=1, MULU/DIVU: at edge k, FSM to RUN, counter=WIDTH, busy_o=1.
  - RUN: one iteration per edge; counter decrements.
  - RUN, edge k+WIDTH (counter reaches 0): outputs written, busy_o=0, FSM to DONE, done_o=1 for the following cycle.
  - DONE: returns to IDLE on the next edge; done_o drops.
  - A start_i asserted during DONE is accepted; it is handled identically to IDLE, so back-to-back single-cycle ops give done_o every cycle.
- start_i while busy_o=1 is ignored; no queuing.
- Outputs hold their last values until the next done_o; they are not cleared at acceptance.
- ADD/SUB arithmetic:
  - Computed on WIDTH+1 bits; cout_o is bit WIDTH.
  - SUB = A + ~B + 1, so cout_o=1 means no borrow.
  - overflow_o = signed overflow of the WIDTH-bit result.
- MULU: unsigned; 2*WIDTH-bit product. result_hi_o = upper half, result_o = lower half.
- DIVU: unsigned restoring divide. result_o = quotient, result_hi_o = remainder.
- Divide by zero still takes WIDTH cycles and produces:
  - result_o = all ones, result_hi_o = src1.
  - overflow_o = 1.
- zero_o is computed from result_o only, for every op.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 -> done_o the cycle after acceptance; result 0x80000000, overflow_o=1, cout_o=0, busy_o never 1. SUB 5-5 -> result 0, zero_o=1, cout_o=1.
- MULU 0xFFFFFFFF*0xFFFFFFFF -> busy_o high for 32 cycles, done_o 33 cycles after the accept edge; result_hi_o=0xFFFFFFFE, result_o=0x00000001.
- DIVU 100/7 -> result_o=14, result_hi_o=2, overflow_o=0. DIVU 9/0 -> result_o=0xFFFFFFFF, result_hi_o=9, overflow_o=1.
- Handshake:
  - start_i held high with new operands during a MULU -> ignored.
  - Back-to-back ADD starts -> done_o on consecutive cycles with correct results.
  - Reset asserted mid-DIVU -> all outputs 0 next cycle, no done_o pulse.
- SLT -1 < 1 -> result 1. SLT 0x80000000 < 0x7FFFFFFF -> result 1. Opcode 1111 -> result 0, zero_o=1.
- WIDTH=8, CNT_W=4: MULU 200*3 -> result_hi_o=0x02, result_o=0x58, 8 busy cycles. DIVU 255/16 -> result_o=15, result_hi_o=15.
